// File: rtl/l2_tlb_pkg.sv
// Helpers shared by the L2 TLB tag/data arrays and the PLRU replacement engine.
// Widths are derived from the associativity and set count and cannot be overridden.
package l2_tlb_pkg;

  localparam int MAX_WAYS = 16;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // One bit per heap node; node 0 is unused, so the state is exactly WAYS bits wide.
  function automatic int plru_state_w(input int ways);
    return ways;
  endfunction

endpackage

// File: rtl/l2_tlb_plru_tree.sv
// Combinational tree-PLRU for a single set: picks a victim (invalid ways first) and
// computes the post-touch state for touch_way.
import l2_tlb_pkg::*;

module l2_tlb_plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = clog2_f(WAYS)
) (
  input  logic [WAYS-1:0]  state,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             from_invalid,
  output logic [WAYS-1:0]  next_state
);

  logic [WAY_W:0]   walk_n;
  logic [WAY_W:0]   upd_n;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] inv_way;

  // Nodes stay below WAYS inside both walks, so the low WAY_W bits index the state.
  always_comb begin
    walk_n = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++)
      walk_n = {walk_n[WAY_W-1:0], state[walk_n[WAY_W-1:0]]};
    plru_way = walk_n[WAY_W-1:0];
  end

  always_comb begin
    next_state = state;
    upd_n      = (WAY_W+1)'(1);
    for (int l = WAY_W-1; l >= 0; l--) begin
      next_state[upd_n[WAY_W-1:0]] = ~touch_way[l];
      upd_n = {upd_n[WAY_W-1:0], touch_way[l]};
    end
    next_state[0] = 1'b0;
  end

  always_comb begin
    inv_way = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (!way_valid[i]) inv_way = WAY_W'(i);
    from_invalid = ~&way_valid;
    victim_way   = from_invalid ? inv_way : plru_way;
  end

endmodule

// File: rtl/l2_tlb_plru_repl.sv
// Per-set tree-PLRU replacement engine for the L2 TLB; victim response one cycle after lookup.
// Optional L2_TLB_REPL_BYPASS_EN: forward a same-cycle touch/flush into the lookup.
import l2_tlb_pkg::*;

module l2_tlb_plru_repl #(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 64,
  localparam int WAY_W = clog2_f(WAYS),
  localparam int SET_W = clog2_f(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lkp_valid,
  input  logic [SET_W-1:0] lkp_set,
  input  logic [WAYS-1:0]  lkp_way_valid,
  output logic             rsp_valid,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_from_invalid,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             flush
);

  logic [SETS-1:0][WAYS-1:0] state_q, state_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [WAY_W-1:0]          rsp_way_q, rsp_way_d;
  logic                      rsp_inv_q, rsp_inv_d;

  logic [WAYS-1:0]  tch_next;
  logic [WAYS-1:0]  lkp_state;
  logic [WAY_W-1:0] lkp_victim;
  logic             lkp_from_inv;
  logic [WAYS-1:0]  lkp_next_unused;
  logic [WAY_W-1:0] tch_victim_unused;
  logic             tch_inv_unused;

  l2_tlb_plru_tree #(.WAYS(WAYS)) u_tch_tree (
    .state        (state_q[touch_set]),
    .way_valid    ({WAYS{1'b1}}),
    .touch_way    (touch_way),
    .victim_way   (tch_victim_unused),
    .from_invalid (tch_inv_unused),
    .next_state   (tch_next)
  );

  always_comb begin
`ifdef L2_TLB_REPL_BYPASS_EN
    if (flush)                                       lkp_state = '0;
    else if (touch_valid && (touch_set == lkp_set))  lkp_state = tch_next;
    else                                             lkp_state = state_q[lkp_set];
`else
    lkp_state = state_q[lkp_set];
`endif
  end

  l2_tlb_plru_tree #(.WAYS(WAYS)) u_lkp_tree (
    .state        (lkp_state),
    .way_valid    (lkp_way_valid),
    .touch_way    ({WAY_W{1'b0}}),
    .victim_way   (lkp_victim),
    .from_invalid (lkp_from_inv),
    .next_state   (lkp_next_unused)
  );

  // Flush beats a same-cycle touch.
  always_comb begin
    state_d = state_q;
    if (flush)            state_d = '0;
    else if (touch_valid) state_d[touch_set] = tch_next;
  end

  always_comb begin
    rsp_valid_d = lkp_valid;
    rsp_way_d   = lkp_valid ? lkp_victim   : rsp_way_q;
    rsp_inv_d   = lkp_valid ? lkp_from_inv : rsp_inv_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_inv_q   <= rsp_inv_d;
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_from_invalid = rsp_inv_q;

endmodule
